// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle for hazard_scoreboard: decode fields, flush/freeze controls,
// and the stall / forwarding-select results returned to the pipeline.
interface hazard_scoreboard_if #(
    parameter int unsigned STAGES   = 3,
    parameter int unsigned REG_BITS = 5
);
    localparam int unsigned SEL_BITS = $clog2(STAGES + 1);

    logic                id_valid;
    logic [REG_BITS-1:0] id_rs1;
    logic [REG_BITS-1:0] id_rs2;
    logic [REG_BITS-1:0] id_rd;
    logic                id_regWrite;
    logic                id_memRead;
    logic                flush;
    logic                freeze;
    logic                stall;
    logic [SEL_BITS-1:0] fwd_sel_1;
    logic [SEL_BITS-1:0] fwd_sel_2;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_regWrite, id_memRead, flush, freeze,
        input  stall, fwd_sel_1, fwd_sel_2
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_regWrite, id_memRead, flush, freeze,
        output stall, fwd_sel_1, fwd_sel_2
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker producing load-use stall and EX forwarding selects.
// Optional stall/flush event counters are built when HAZARD_STATS_EN is defined.
module hazard_scoreboard #(
    parameter int unsigned STAGES      = 3,
    parameter int unsigned LOAD_AVAIL  = 3,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned REG_BITS    = 5
) (
    input  logic               clock,
    input  logic               reset,
    hazard_scoreboard_if.slave hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]        stall_count,
    output logic [31:0]        flush_count
`endif
);
    localparam int unsigned SEL_BITS = $clog2(STAGES + 1);

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rd;
        logic                reg_write;
        logic                mem_read;
    } entry_t;

    entry_t [STAGES:1]   ent_q, ent_d;
    logic [REG_BITS-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [STAGES:1]     live;
    logic                stall;
    logic [SEL_BITS-1:0] sel1, sel2;

    always_comb begin
        live = '0;
        for (int k = 1; k <= int'(STAGES); k++) begin
            live[k] = ent_q[k].valid & ent_q[k].reg_write & (ent_q[k].rd != '0);
        end
    end

    // Only loads too young to reach LOAD_AVAIL by the dependent's EX cycle stall.
    always_comb begin
        stall = 1'b0;
        for (int k = 1; k <= int'(STAGES); k++) begin
            if ((k + 2 <= int'(LOAD_AVAIL)) && live[k] && ent_q[k].mem_read &&
                ((ent_q[k].rd == hz.id_rs1) || (ent_q[k].rd == hz.id_rs2))) begin
                stall = 1'b1;
            end
        end
        if (!hz.id_valid || hz.flush) begin
            stall = 1'b0;
        end
    end

    // Walk oldest to youngest so the youngest matching writer overrides.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int k = int'(STAGES); k >= 2; k--) begin
            if (live[k] && !(ent_q[k].mem_read && (k < int'(LOAD_AVAIL)))) begin
                if (ent_q[k].rd == rs1_q) sel1 = SEL_BITS'(k);
                if (ent_q[k].rd == rs2_q) sel2 = SEL_BITS'(k);
            end
        end
    end

    assign hz.stall     = stall;
    assign hz.fwd_sel_1 = sel1;
    assign hz.fwd_sel_2 = sel2;

    always_comb begin
        ent_d = ent_q;
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        if (!hz.freeze) begin
            for (int k = 2; k <= int'(STAGES); k++) begin
                ent_d[k] = ent_q[k-1];
            end
            if (hz.id_valid && !stall && !hz.flush) begin
                ent_d[1].valid     = 1'b1;
                ent_d[1].rd        = hz.id_rd;
                ent_d[1].reg_write = hz.id_regWrite;
                ent_d[1].mem_read  = hz.id_memRead;
                rs1_d              = hz.id_rs1;
                rs2_d              = hz.id_rs2;
            end else begin
                ent_d[1] = '0;
                rs1_d    = '0;
                rs2_d    = '0;
            end
            if (hz.flush) begin
                for (int k = 1; k <= int'(FLUSH_DEPTH); k++) begin
                    ent_d[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ent_q <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
        end else begin
            ent_q <= ent_d;
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!hz.freeze) begin
            if (stall)    stall_cnt_q <= stall_cnt_q + 32'd1;
            if (hz.flush) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default 3-stage instance plus a
// STAGES=5 / LOAD_AVAIL=4 instance; counter checks build with HAZARD_STATS_EN.
module tb_hazard_scoreboard;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    hazard_scoreboard_if #(.STAGES(3), .REG_BITS(5)) bus3 ();
    hazard_scoreboard_if #(.STAGES(5), .REG_BITS(5)) bus5 ();

`ifdef HAZARD_STATS_EN
    logic [31:0] sc3, fc3, sc5, fc5;
`endif

    hazard_scoreboard #(.STAGES(3), .LOAD_AVAIL(3), .FLUSH_DEPTH(2), .REG_BITS(5)) dut3 (
        .clock(clock),
        .reset(reset),
        .hz   (bus3)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count(sc3),
        .flush_count(fc3)
`endif
    );

    hazard_scoreboard #(.STAGES(5), .LOAD_AVAIL(4), .FLUSH_DEPTH(2), .REG_BITS(5)) dut5 (
        .clock(clock),
        .reset(reset),
        .hz   (bus5)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count(sc5),
        .flush_count(fc5)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic id3(input logic v, input logic [4:0] r1, r2, rd, input logic rw, mr);
        bus3.id_valid    = v;
        bus3.id_rs1      = r1;
        bus3.id_rs2      = r2;
        bus3.id_rd       = rd;
        bus3.id_regWrite = rw;
        bus3.id_memRead  = mr;
    endtask

    task automatic id5(input logic v, input logic [4:0] r1, r2, rd, input logic rw, mr);
        bus5.id_valid    = v;
        bus5.id_rs1      = r1;
        bus5.id_rs2      = r2;
        bus5.id_rd       = rd;
        bus5.id_regWrite = rw;
        bus5.id_memRead  = mr;
    endtask

    task automatic rand_in();
        id3(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
        id5(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
        bus3.flush  = 1'($urandom);
        bus3.freeze = 1'($urandom);
        bus5.flush  = 1'($urandom);
        bus5.freeze = 1'($urandom);
    endtask

    initial begin
        // Reset held for three cycles under random inputs
        for (int i = 0; i < 3; i++) begin
            rand_in();
            tick();
            chk("rst_stall", 32'(bus3.stall), 0);
            chk("rst_fwd1", 32'(bus3.fwd_sel_1), 0);
            chk("rst_fwd2", 32'(bus3.fwd_sel_2), 0);
            chk("rst_stall5", 32'(bus5.stall), 0);
        end
`ifdef HAZARD_STATS_EN
        chk("rst_scnt", sc3, 0);
        chk("rst_fcnt", fc3, 0);
`endif
        id3(0, 0, 0, 0, 0, 0);
        id5(0, 0, 0, 0, 0, 0);
        bus3.flush  = 1'b0;
        bus3.freeze = 1'b0;
        bus5.flush  = 1'b0;
        bus5.freeze = 1'b0;
        reset = 1'b1;
        #1;

        // Load-use: lw x5 ; add x6,x5,x1
        id3(1, 2, 0, 5, 1, 1); #1;
        chk("lu_pre_stall", 32'(bus3.stall), 0);
        tick();
        id3(1, 5, 1, 6, 1, 0); #1;
        chk("lu_stall", 32'(bus3.stall), 1);
        tick();
        chk("lu_release", 32'(bus3.stall), 0);
        tick();
        id3(0, 0, 0, 0, 0, 0); #1;
        chk("lu_fwd1", 32'(bus3.fwd_sel_1), 3);
        chk("lu_fwd2", 32'(bus3.fwd_sel_2), 0);
`ifdef HAZARD_STATS_EN
        chk("lu_scnt", sc3, 1);
`endif
        tick();

        // Youngest priority: addi x7 ; addi x7 ; sub x8,x7,x7
        id3(1, 1, 0, 7, 1, 0); tick();
        id3(1, 3, 0, 7, 1, 0); tick();
        id3(1, 7, 7, 8, 1, 0); #1;
        chk("yp_nostall", 32'(bus3.stall), 0);
        tick();
        id3(0, 0, 0, 0, 0, 0); #1;
        chk("yp_fwd1", 32'(bus3.fwd_sel_1), 2);
        chk("yp_fwd2", 32'(bus3.fwd_sel_2), 2);
        tick();

        // x0 destination never forwards
        id3(1, 1, 0, 0, 1, 0); tick();
        id3(1, 0, 0, 9, 1, 0); tick();
        id3(0, 0, 0, 0, 0, 0); #1;
        chk("x0_fwd1", 32'(bus3.fwd_sel_1), 0);
        chk("x0_fwd2", 32'(bus3.fwd_sel_2), 0);
        tick();

        // Flush with a load in entry 1 and its dependent in ID
        id3(1, 9, 0, 10, 1, 1); tick();
        id3(1, 10, 10, 11, 1, 0);
        bus3.flush = 1'b1; #1;
        chk("fl_stall", 32'(bus3.stall), 0);
        chk("fl_fwd1_e3", 32'(bus3.fwd_sel_1), 3);
        tick();
        bus3.flush = 1'b0; #1;
        chk("fl_after_stall", 32'(bus3.stall), 0);
`ifdef HAZARD_STATS_EN
        chk("fl_fcnt", fc3, 1);
        chk("fl_scnt", sc3, 1);
`endif
        tick();
        id3(0, 0, 0, 0, 0, 0); #1;
        chk("fl_fwd1", 32'(bus3.fwd_sel_1), 0);
        chk("fl_fwd2", 32'(bus3.fwd_sel_2), 0);
        tick();

        // Freeze for four cycles over a load-use hazard
        id3(1, 0, 0, 12, 1, 1); tick();
        id3(1, 12, 0, 13, 1, 0);
        bus3.freeze = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            chk("frz_stall", 32'(bus3.stall), 1);
            tick();
        end
`ifdef HAZARD_STATS_EN
        chk("frz_scnt", sc3, 1);
`endif
        bus3.freeze = 1'b0; #1;
        chk("frz_rel_stall", 32'(bus3.stall), 1);
        tick();
        chk("frz_post_stall", 32'(bus3.stall), 0);
`ifdef HAZARD_STATS_EN
        chk("frz_post_scnt", sc3, 2);
`endif
        tick();
        id3(0, 0, 0, 0, 0, 0); #1;
        chk("frz_fwd1", 32'(bus3.fwd_sel_1), 3);
        chk("frz_fwd2", 32'(bus3.fwd_sel_2), 0);
        tick();

        // STAGES=5, LOAD_AVAIL=4: two stall cycles then select 4
        id5(1, 2, 0, 5, 1, 1); tick();
        id5(1, 5, 1, 6, 1, 0); #1;
        chk("sw_stall1", 32'(bus5.stall), 1);
        tick();
        chk("sw_stall2", 32'(bus5.stall), 1);
        tick();
        chk("sw_stall3", 32'(bus5.stall), 0);
        tick();
        id5(0, 0, 0, 0, 0, 0); #1;
        chk("sw_fwd1", 32'(bus5.fwd_sel_1), 4);
        chk("sw_fwd2", 32'(bus5.fwd_sel_2), 0);
`ifdef HAZARD_STATS_EN
        chk("sw_scnt", sc5, 2);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
